// File: rtl/cpu_ahb_slave_bridge.sv
// AHB slave bridge that gives the host IM/DM load, CPU run control and RF polling on one port.
// Optional macro AHB_ERR_RESP_EN: unmapped or locked accesses return a one-cycle ERROR on S_HRESP.
module cpu_ahb_slave_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          IM_DEPTH  = 2048,
    parameter int          DM_DEPTH  = 2048,
    parameter logic [31:0] ID_VALUE  = 32'hC0DE_0001
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        S_HSEL,
    input  logic [31:0]                 S_HADDR,
    input  logic [2:0]                  S_HBURST,
    input  logic [1:0]                  S_HTRANS,
    input  logic [2:0]                  S_HSIZE,
    input  logic [3:0]                  S_HPROT,
    input  logic                        S_HWRITE,
    input  logic [31:0]                 S_HWDATA,
    output logic                        S_HREADY,
    output logic [31:0]                 S_HRDATA,
    output logic                        S_HRESP,
    output logic                        cpu_rstn,
    output logic                        im_we,
    output logic [$clog2(IM_DEPTH)-1:0] im_addr,
    output logic [31:0]                 im_wdata,
    output logic                        dm_en,
    output logic                        dm_we,
    output logic [$clog2(DM_DEPTH)-1:0] dm_addr,
    output logic [31:0]                 dm_wdata,
    input  logic [31:0]                 dm_rdata,
    output logic [4:0]                  rf_raddr,
    input  logic [31:0]                 rf_rdata
);

    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int DM_AW = $clog2(DM_DEPTH);

    logic [31:0] offset;
    logic        selIm, selDm, selRf, selId, selCtrl;
    logic        halted, wrXfer, rdXfer;
    logic [31:0] rdData_q, rdData_d;
    logic        cpuRun_q, cpuRun_d;
    logic        unusedBits;

    assign offset  = S_HADDR - BASE_ADDR;
    assign selIm   = (offset[31:13] == 19'd0);
    assign selDm   = (offset[31:13] == 19'd1);
    assign selRf   = (offset[31:7]  == 25'h80);
    assign selId   = (offset[31:2]  == 30'h2000);
    assign selCtrl = (offset[31:2]  == 30'h2001);

    assign halted  = !cpuRun_q;
    assign wrXfer  = S_HSEL && S_HWRITE && !HRESET;
    assign rdXfer  = S_HSEL && !S_HWRITE && !HRESET;

    // Memory ports are driven straight from the bus so the core commits on the sampling edge.
    assign im_we    = wrXfer && selIm && halted;
    assign im_addr  = offset[IM_AW+1:2];
    assign im_wdata = S_HWDATA;
    assign dm_en    = S_HSEL && !HRESET && selDm && halted;
    assign dm_we    = dm_en && S_HWRITE;
    assign dm_addr  = offset[DM_AW+1:2];
    assign dm_wdata = S_HWDATA;
    assign rf_raddr = offset[6:2];

    assign S_HREADY = 1'b1;
    assign S_HRDATA = rdData_q;
    assign cpu_rstn = cpuRun_q;

    assign unusedBits = ^{S_HBURST, S_HTRANS, S_HSIZE, S_HPROT, offset[1:0], S_HWDATA[31:1]};

    // DM read data arrives a cycle after dm_en, so a held DM address captures it on the second edge.
    always_comb begin
        rdData_d = rdData_q;
        cpuRun_d = cpuRun_q;
        if (rdXfer) begin
            if (selDm)
                rdData_d = halted ? dm_rdata : 32'd0;
            else if (selRf)
                rdData_d = rf_rdata;
            else if (selId)
                rdData_d = ID_VALUE;
            else if (selCtrl)
                rdData_d = {31'd0, cpuRun_q};
            else
                rdData_d = 32'd0;
        end
        if (wrXfer && selCtrl)
            cpuRun_d = S_HWDATA[0];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rdData_q <= 32'd0;
            cpuRun_q <= 1'b0;
        end else begin
            rdData_q <= rdData_d;
            cpuRun_q <= cpuRun_d;
        end
    end

`ifdef AHB_ERR_RESP_EN
    logic resp_q, resp_d;
    logic mapped;

    assign mapped  = selIm || selDm || selRf || selId || selCtrl;
    assign resp_d  = S_HSEL && !HRESET && (!mapped || ((selIm || selDm) && !halted));
    assign S_HRESP = resp_q;

    always_ff @(posedge HCLK) begin
        if (HRESET)
            resp_q <= 1'b0;
        else
            resp_q <= resp_d;
    end
`else
    assign S_HRESP = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ahb_slave_bridge.sv
// Directed bench for cpu_ahb_slave_bridge with small DM and RF models standing in for the core.
module tb_cpu_ahb_slave_bridge;

    logic        HCLK;
    logic        HRESET;
    logic        S_HSEL;
    logic [31:0] S_HADDR;
    logic [2:0]  S_HBURST;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic [3:0]  S_HPROT;
    logic        S_HWRITE;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic [31:0] S_HRDATA;
    logic        S_HRESP;
    logic        cpu_rstn;
    logic        im_we;
    logic [10:0] im_addr;
    logic [31:0] im_wdata;
    logic        dm_en;
    logic        dm_we;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;

    int checks = 0;
    int errors = 0;
    logic expErr;

    cpu_ahb_slave_bridge dut (
        .HCLK(HCLK), .HRESET(HRESET), .S_HSEL(S_HSEL), .S_HADDR(S_HADDR),
        .S_HBURST(S_HBURST), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HPROT(S_HPROT),
        .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA),
        .S_HRESP(S_HRESP), .cpu_rstn(cpu_rstn), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Synchronous DM model: read-before-write, data valid the cycle after dm_en.
    logic [31:0] dmMem [0:2047];
    always @(posedge HCLK) begin
        if (dm_en) begin
            if (dm_we) dmMem[dm_addr] <= dm_wdata;
            dm_rdata <= dmMem[dm_addr];
        end
    end

    always_comb rf_rdata = (rf_raddr == 5'd6) ? 32'h0000_04D2 : (32'h100 + {27'd0, rf_raddr});

    task automatic setBus(input logic sel, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        S_HSEL   = sel;
        S_HWRITE = wr;
        S_HADDR  = addr;
        S_HWDATA = data;
        S_HBURST = 3'($urandom);
        S_HTRANS = 2'($urandom);
        S_HSIZE  = 3'($urandom);
        S_HPROT  = 4'($urandom);
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        setBus(1'b1, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF);
        #1;
        checks++; if (im_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_im_we: got %b expected 0", im_we); end
        tick; tick;
        setBus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_rstn: got %b expected 0", cpu_rstn); end
        checks++; if (S_HRDATA !== 32'd0) begin errors++; $display("[TB] FAIL reset_hrdata: got %h expected 0", S_HRDATA); end
        checks++; if (S_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp: got %b expected 0", S_HRESP); end
        checks++; if (S_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL reset_hready: got %b expected 1", S_HREADY); end
        HRESET = 1'b0;
        tick;
    endtask

    task automatic test_im_write;
        setBus(1'b1, 1'b1, 32'h4000_0000, 32'h0000_0013);
        #1;
        checks++; if (im_we !== 1'b1) begin errors++; $display("[TB] FAIL im_we: got %b expected 1", im_we); end
        checks++; if (im_addr !== 11'd0) begin errors++; $display("[TB] FAIL im_addr0: got %h expected 000", im_addr); end
        checks++; if (im_wdata !== 32'h13) begin errors++; $display("[TB] FAIL im_wdata: got %h expected 00000013", im_wdata); end
        checks++; if (dm_en !== 1'b0) begin errors++; $display("[TB] FAIL im_dm_en: got %b expected 0", dm_en); end
        tick;
        setBus(1'b1, 1'b1, 32'h4000_1FFE, 32'hA5A5_A5A5);
        #1;
        checks++; if (im_addr !== 11'h7FF) begin errors++; $display("[TB] FAIL im_addr_top: got %h expected 7ff", im_addr); end
        tick;
        setBus(1'b1, 1'b0, 32'h4000_0000, 32'h0);
        tick;
        checks++; if (S_HRDATA !== 32'd0) begin errors++; $display("[TB] FAIL im_read_zero: got %h expected 0", S_HRDATA); end
    endtask

    task automatic test_dm_readwrite;
        setBus(1'b1, 1'b1, 32'h4000_3FFC, 32'h3F80_0000);
        #1;
        checks++; if ({dm_en, dm_we} !== 2'b11) begin errors++; $display("[TB] FAIL dm_wr_strobe: got %b expected 11", {dm_en, dm_we}); end
        checks++; if (dm_addr !== 11'h7FF) begin errors++; $display("[TB] FAIL dm_addr: got %h expected 7ff", dm_addr); end
        checks++; if (dm_wdata !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL dm_wdata: got %h expected 3f800000", dm_wdata); end
        tick;
        setBus(1'b1, 1'b0, 32'h4000_3FFC, 32'h0);
        #1;
        checks++; if ({dm_en, dm_we} !== 2'b10) begin errors++; $display("[TB] FAIL dm_rd_strobe: got %b expected 10", {dm_en, dm_we}); end
        tick; tick;
        checks++; if (S_HRDATA !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL dm_read: got %h expected 3f800000", S_HRDATA); end
        setBus(1'b0, 1'b1, 32'h4000_2000, 32'h1);
        #1;
        checks++; if (dm_en !== 1'b0) begin errors++; $display("[TB] FAIL hsel0_dm_en: got %b expected 0", dm_en); end
        tick;
        checks++; if (S_HRDATA !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL hrdata_hold: got %h expected 3f800000", S_HRDATA); end
    endtask

    task automatic test_rf_and_id;
        setBus(1'b1, 1'b0, 32'h4000_4018, 32'h0);
        #1;
        checks++; if (rf_raddr !== 5'd6) begin errors++; $display("[TB] FAIL rf_raddr: got %0d expected 6", rf_raddr); end
        tick;
        checks++; if (S_HRDATA !== 32'h0000_04D2) begin errors++; $display("[TB] FAIL rf_read6: got %h expected 000004d2", S_HRDATA); end
        setBus(1'b1, 1'b0, 32'h4000_407C, 32'h0);
        tick;
        checks++; if (S_HRDATA !== 32'h0000_011F) begin errors++; $display("[TB] FAIL rf_read31: got %h expected 0000011f", S_HRDATA); end
        setBus(1'b1, 1'b0, 32'h4000_8003, 32'h0);
        tick;
        checks++; if (S_HRDATA !== 32'hC0DE_0001) begin errors++; $display("[TB] FAIL id_read: got %h expected c0de0001", S_HRDATA); end
    endtask

    task automatic test_ctrl;
        setBus(1'b1, 1'b1, 32'h4000_8004, 32'h0000_0001);
        tick;
        checks++; if (cpu_rstn !== 1'b1) begin errors++; $display("[TB] FAIL ctrl_run: got %b expected 1", cpu_rstn); end
        checks++; if (S_HRDATA !== 32'hC0DE_0001) begin errors++; $display("[TB] FAIL ctrl_wr_hold: got %h expected c0de0001", S_HRDATA); end
        setBus(1'b1, 1'b0, 32'h4000_8004, 32'h0);
        tick;
        checks++; if (S_HRDATA !== 32'h1) begin errors++; $display("[TB] FAIL ctrl_read: got %h expected 00000001", S_HRDATA); end
    endtask

    task automatic test_locked;
        setBus(1'b1, 1'b1, 32'h4000_2004, 32'h5555_AAAA);
        #1;
        checks++; if (dm_en !== 1'b0) begin errors++; $display("[TB] FAIL locked_dm_en: got %b expected 0", dm_en); end
        tick;
        checks++; if (S_HRESP !== expErr) begin errors++; $display("[TB] FAIL locked_hresp: got %b expected %b", S_HRESP, expErr); end
        setBus(1'b1, 1'b1, 32'h4000_0010, 32'h1234_5678);
        #1;
        checks++; if (im_we !== 1'b0) begin errors++; $display("[TB] FAIL locked_im_we: got %b expected 0", im_we); end
        tick;
        setBus(1'b1, 1'b0, 32'h4000_3FFC, 32'h0);
        tick; tick;
        checks++; if (S_HRDATA !== 32'd0) begin errors++; $display("[TB] FAIL locked_dm_read: got %h expected 0", S_HRDATA); end
        setBus(1'b1, 1'b0, 32'h4000_4018, 32'h0);
        tick;
        checks++; if (S_HRDATA !== 32'h0000_04D2) begin errors++; $display("[TB] FAIL running_rf_read: got %h expected 000004d2", S_HRDATA); end
        checks++; if (S_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL rf_hresp: got %b expected 0", S_HRESP); end
    endtask

    task automatic test_unmapped;
        setBus(1'b1, 1'b0, 32'h4001_0000, 32'h0);
        tick;
        checks++; if (S_HRDATA !== 32'd0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 0", S_HRDATA); end
        checks++; if (S_HRESP !== expErr) begin errors++; $display("[TB] FAIL unmapped_hresp: got %b expected %b", S_HRESP, expErr); end
        setBus(1'b1, 1'b1, 32'h3FFF_FFFC, 32'h0);
        tick;
        checks++; if (cpu_rstn !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_write_ctrl: got %b expected 1", cpu_rstn); end
        setBus(1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        checks++; if (S_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL hresp_one_cycle: got %b expected 0", S_HRESP); end
    endtask

    task automatic test_back_to_back;
        setBus(1'b1, 1'b1, 32'h4000_8004, 32'h0);
        tick;
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_halt: got %b expected 0", cpu_rstn); end
        setBus(1'b1, 1'b1, 32'h4000_2010, 32'h0000_0011);
        tick;
        setBus(1'b1, 1'b1, 32'h4000_2010, 32'h0000_0022);
        tick;
        setBus(1'b1, 1'b0, 32'h4000_2010, 32'h0);
        tick; tick;
        checks++; if (S_HRDATA !== 32'h0000_0022) begin errors++; $display("[TB] FAIL b2b_dm_read: got %h expected 00000022", S_HRDATA); end
    endtask

    task automatic test_reset_again;
        setBus(1'b1, 1'b1, 32'h4000_8004, 32'h1);
        tick;
        setBus(1'b1, 1'b0, 32'h4000_8000, 32'h0);
        tick;
        setBus(1'b0, 1'b0, 32'h0, 32'h0);
        HRESET = 1'b1;
        tick;
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("[TB] FAIL rerst_cpu_rstn: got %b expected 0", cpu_rstn); end
        checks++; if (S_HRDATA !== 32'd0) begin errors++; $display("[TB] FAIL rerst_hrdata: got %h expected 0", S_HRDATA); end
        HRESET = 1'b0;
        tick;
    endtask

    initial begin
`ifdef AHB_ERR_RESP_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        HRESET = 1'b1;
        setBus(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset;
        test_im_write;
        test_dm_readwrite;
        test_rf_and_id;
        test_ctrl;
        test_locked;
        test_unmapped;
        test_back_to_back;
        test_reset_again;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
